serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell
//  (sum=a^b^c, carry=majority). Accepts WIDTH-bit operands via valid/ready, feeds
//  one bit pair per clock LSB-first through the cell with a registered carry, and

---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer using a single 1-bit
// full-adder cell with a registered carry. Operands are taken in IDLE,
// processed LSB-first over WIDTH clocks, and the result is held until consumed.
// Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output port (ovf).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;

  // The one full-adder cell: operand LSBs plus the registered carry.
  logic cell_sum;
  logic cell_carry;
  logic last_bit;

  assign cell_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign cell_carry = (a_sh_reg[0] & b_sh_reg[0]) |
                      (a_sh_reg[0] & carry_reg)   |
                      (b_sh_reg[0] & carry_reg);
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

  // Sequencer: accept in IDLE, shift one bit per clock in RUN, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum_out   <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtraction is A + ~B + 1: invert B here and force carry-in.
            a_sh_reg  <= a_in;
            b_sh_reg  <= b_in ^ {WIDTH{sub}};
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            // Ready rises on the first clock after reset and stays up in IDLE.
            in_ready  <= 1'b1;
          end
        end
        RUN: begin
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          res_reg   <= {cell_sum, res_reg[WIDTH-1:1]};
          carry_reg <= cell_carry;
          if (last_bit) begin
            // Final bit: publish result; carry_reg is the carry into the MSB.
            sum_out   <= {cell_sum, res_reg[WIDTH-1:1]};
            cout      <= cell_carry;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= carry_reg ^ cell_carry;
`endif
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // No new accept here; ready only reappears once back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8). Compile with
// +define+SERIAL_ADD_OVF_EN to also check the ovf port.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       sub;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int tests_run;
  int tests_failed;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Wait for out_valid; returns edges counted since call.
  task automatic wait_result(input string tag, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    if (!out_valid) chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    chk({tag, "_sum"}, 32'(sum_out), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] %s unexpected X ovf", tag);
`endif
  endtask

  // Full transaction: accept, measure latency, check result, consume.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
    int cyc;
    wait_ready(tag);
    a_in = a; b_in = b; sub = s; cin = c; in_valid = 1'b1;
    tick();                                  // accept edge
    in_valid = 1'b0;
    a_in = ~a; b_in = ~b; cin = ~c;          // later changes must be ignored
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_result(tag, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd8);
    check_result(tag, es, ec, eo);
    chk({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();                                  // consume edge
    out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_inrdy_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_sum_held"}, 32'(sum_out), 32'(es));
    $display("[TB] %s a=%02h b=%02h sub=%0b cin=%0b -> sum=%02h cout=%0b", tag, a, b, s, c, sum_out, cout);
  endtask

  initial begin
    int cyc;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = 8'h00; b_in = 8'h00; sub = 1'b0; cin = 1'b0;

    // Reset state
    #12;
    chk("rst_inrdy", 32'(in_ready), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_inrdy", 32'(in_ready), 32'd1);
    $display("[TB] reset released, in_ready=%0b", in_ready);

    // Basic add, wrap, subtract
    do_op("add",   8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("wrap2", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op("sub1",  8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    do_op("sub2",  8'h20, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0);

    // Backpressure and ignored requests while busy
    wait_ready("bp");
    a_in = 8'h33; b_in = 8'h44; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    a_in = 8'hAA; b_in = 8'h55; in_valid = 1'b1;   // pulse during RUN
    chk("bp_run_inrdy", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_result("bp", cyc);
    check_result("bp", 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum_out), 32'h77);
      chk("bp_hold_inrdy", 32'(in_ready), 32'd0);
    end
    a_in = 8'hC8; b_in = 8'h64; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();                                   // consume edge: no accept in DONE
    out_ready = 1'b0;
    chk("bp_noacc_busy", 32'(busy), 32'd0);
    chk("bp_noacc_inrdy", 32'(in_ready), 32'd1);
    tick();                                   // first IDLE cycle: accepted
    in_valid = 1'b0;
    chk("bp_acc_busy", 32'(busy), 32'd1);
    wait_result("bp2", cyc);
    chk("bp2_lat", 32'(cyc), 32'd8);
    check_result("bp2", 8'h2D, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("[TB] backpressure sequence done, sum=%02h", sum_out);

    // Reset mid-RUN at counter 3
    wait_ready("mr");
    a_in = 8'h0F; b_in = 8'h0F; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ovalid", 32'(out_valid), 32'd0);
    chk("mr_inrdy", 32'(in_ready), 32'd0);
    chk("mr_sum", 32'(sum_out), 32'd0);
    chk("mr_cout", 32'(cout), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("mr_inrdy_next", 32'(in_ready), 32'd1);
    chk("mr_ovalid_next", 32'(out_valid), 32'd0);
    $display("[TB] mid-run reset applied");
    do_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
